// File: rtl/rvs_xrf_wb_arbiter_if.sv
// Retire-to-XRF writeback bundle: retire-side valid/ready lanes, XRF write ports and occupancy status.
// The arbiter connects through the slave modport; the retire stage and XRF side connect through master.
interface rvs_xrf_wb_arbiter_if #(
    parameter int NUM_RT_UOP   = 4,
    parameter int XRF_WR_PORTS = 1,
    parameter int FIFO_DEPTH   = 8,
    parameter int XRF_ADDR_W   = 5,
    parameter int XLEN         = 32
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_RT_UOP-1:0]              rt_xrf_valid;
    logic [NUM_RT_UOP*XRF_ADDR_W-1:0]   rt_xrf_index;
    logic [NUM_RT_UOP*XLEN-1:0]         rt_xrf_data;
    logic [NUM_RT_UOP-1:0]              rt_xrf_ready;
    logic                               xrf_wr_stall;
    logic [XRF_WR_PORTS-1:0]            xrf_wr_en;
    logic [XRF_WR_PORTS*XRF_ADDR_W-1:0] xrf_wr_addr;
    logic [XRF_WR_PORTS*XLEN-1:0]       xrf_wr_data;
    logic [CNT_W-1:0]                   fifo_count;
    logic                               wb_idle;

    modport slave (
        input  rt_xrf_valid, rt_xrf_index, rt_xrf_data, xrf_wr_stall,
        output rt_xrf_ready, xrf_wr_en, xrf_wr_addr, xrf_wr_data, fifo_count, wb_idle
    );

    modport master (
        output rt_xrf_valid, rt_xrf_index, rt_xrf_data, xrf_wr_stall,
        input  rt_xrf_ready, xrf_wr_en, xrf_wr_addr, xrf_wr_data, fifo_count, wb_idle
    );
endinterface

// File: rtl/rvs_xrf_wb_arbiter.sv
// RVV retire writeback queue: compacts accepted retire lanes into an in-order FIFO and drains
// it onto the XRF write ports, dropping x0 writes and letting the youngest same-address write win.
module rvs_xrf_wb_arbiter #(
    parameter int NUM_RT_UOP   = 4,
    parameter int XRF_WR_PORTS = 1,
    parameter int FIFO_DEPTH   = 8,
    parameter int XRF_ADDR_W   = 5,
    parameter int XLEN         = 32
) (
    input logic                clk,
    input logic                rst,
    rvs_xrf_wb_arbiter_if.slave wb
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XRF_ADDR_W-1:0]   idx_q [FIFO_DEPTH];
    logic [XLEN-1:0]         dat_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d, push_cnt_s, pop_cnt_s;
    logic [NUM_RT_UOP-1:0]   ready_s, push_s;
    logic [PTR_W-1:0]        lane_slot_s [NUM_RT_UOP];
    logic [XRF_WR_PORTS-1:0] cand_s, en_s;
    logic [XRF_ADDR_W-1:0]   port_idx_s [XRF_WR_PORTS];
    logic [XLEN-1:0]         port_dat_s [XRF_WR_PORTS];

    // Lane readiness from registered free space only, so valid never feeds ready.
    always_comb begin
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            ready_s[i] = (CNT_W'(FIFO_DEPTH) - count_q) > CNT_W'(i);
        end
    end

    // Accepted lanes take consecutive slots in lane order.
    always_comb begin
        push_cnt_s = '0;
        push_s     = '0;
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            lane_slot_s[i] = wr_ptr_q + PTR_W'(push_cnt_s);
            push_s[i]      = wb.rt_xrf_valid[i] & ready_s[i];
            if (push_s[i]) begin
                push_cnt_s = push_cnt_s + CNT_W'(1);
            end else begin
                push_cnt_s = push_cnt_s;
            end
        end
    end

    // Drain group from the head; a candidate loses its enable to x0 or to any younger same-index candidate.
    always_comb begin
        pop_cnt_s = '0;
        en_s      = '0;
        for (int k = 0; k < XRF_WR_PORTS; k++) begin
            port_idx_s[k] = idx_q[rd_ptr_q + PTR_W'(k)];
            port_dat_s[k] = dat_q[rd_ptr_q + PTR_W'(k)];
            cand_s[k]     = count_q > CNT_W'(k);
        end
        for (int k = 0; k < XRF_WR_PORTS; k++) begin
            en_s[k] = cand_s[k] & ~wb.xrf_wr_stall & (port_idx_s[k] != '0);
            for (int j = k + 1; j < XRF_WR_PORTS; j++) begin
                if (cand_s[j] && (port_idx_s[j] == port_idx_s[k])) begin
                    en_s[k] = 1'b0;
                end else begin
                    en_s[k] = en_s[k];
                end
            end
            if (cand_s[k] && !wb.xrf_wr_stall) begin
                pop_cnt_s = pop_cnt_s + CNT_W'(1);
            end else begin
                pop_cnt_s = pop_cnt_s;
            end
        end
    end

    // Pointer and occupancy next state; pointers wrap naturally at FIFO_DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt_s);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt_s);
        count_d  = count_q + push_cnt_s - pop_cnt_s;
    end

    // Queue control state with synchronous reset discarding all entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless outside the occupied window.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            if (push_s[i]) begin
                idx_q[lane_slot_s[i]] <= wb.rt_xrf_index[i*XRF_ADDR_W +: XRF_ADDR_W];
                dat_q[lane_slot_s[i]] <= wb.rt_xrf_data[i*XLEN +: XLEN];
            end
        end
    end

    // Flatten per-port head entries onto the write bus.
    always_comb begin
        wb.xrf_wr_addr = '0;
        wb.xrf_wr_data = '0;
        for (int k = 0; k < XRF_WR_PORTS; k++) begin
            wb.xrf_wr_addr[k*XRF_ADDR_W +: XRF_ADDR_W] = port_idx_s[k];
            wb.xrf_wr_data[k*XLEN +: XLEN]             = port_dat_s[k];
        end
    end

    assign wb.rt_xrf_ready = ready_s;
    assign wb.xrf_wr_en    = en_s;
    assign wb.fifo_count   = count_q;
    assign wb.wb_idle      = (count_q == '0);

    rvs_xrf_wb_arbiter_chk #(
        .NUM_RT_UOP (NUM_RT_UOP),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .valid_i (wb.rt_xrf_valid),
        .count_i (count_q)
    );
endmodule

// Protocol and occupancy properties of the writeback queue.
module rvs_xrf_wb_arbiter_chk #(
    parameter int NUM_RT_UOP = 4,
    parameter int FIFO_DEPTH = 8
) (
    input logic                            clk,
    input logic                            rst,
    input logic [NUM_RT_UOP-1:0]           valid_i,
    input logic [$clog2(FIFO_DEPTH):0]     count_i
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // A valid prefix has no set bit above a clear bit, so adding one clears every set bit.
    a_valid_prefix: assert property (@(posedge clk) disable iff (rst)
        ((valid_i & (valid_i + NUM_RT_UOP'(1))) == NUM_RT_UOP'(0)));

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        (count_i <= CNT_W'(FIFO_DEPTH)));
endmodule

// File: tb/tb_rvs_xrf_wb_arbiter.sv
// Bench for rvs_xrf_wb_arbiter: per-cycle vector table plus a write scoreboard on the 1-port
// instance, and hand sequences on a 2-port instance for same-cycle collisions.
module tb_rvs_xrf_wb_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    rvs_xrf_wb_arbiter_if #(.XRF_WR_PORTS(1)) bus1 ();
    rvs_xrf_wb_arbiter_if #(.XRF_WR_PORTS(2)) bus2 ();

    rvs_xrf_wb_arbiter #(.XRF_WR_PORTS(1)) dut1 (.clk(clk), .rst(rst), .wb(bus1.slave));
    rvs_xrf_wb_arbiter #(.XRF_WR_PORTS(2)) dut2 (.clk(clk), .rst(rst), .wb(bus2.slave));

    typedef struct {
        logic         rst;
        logic         stall;
        logic [3:0]   valid;
        logic [19:0]  idx;
        logic [127:0] data;
        logic [3:0]   rdy;
        int           cnt;
    } vec_t;
    vec_t vecs[$];

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t sb_q[$];
    int  model_cnt = 0;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void add(logic r, logic s, logic [3:0] v, logic [19:0] ix,
                                logic [127:0] dt, logic [3:0] rd, int c);
        vec_t e;
        e.rst = r; e.stall = s; e.valid = v; e.idx = ix; e.data = dt; e.rdy = rd; e.cnt = c;
        vecs.push_back(e);
    endfunction

    // Scoreboard on the 1-port instance: independent occupancy model, in-order expected writes.
    always @(negedge clk) begin
        logic [3:0] exp_rdy;
        wr_t        e;
        int         pushes;
        int         pops;
        if (rst) begin
            sb_q.delete();
            model_cnt = 0;
        end else begin
            for (int i = 0; i < 4; i++) exp_rdy[i] = (8 - model_cnt) > i;
            chk("mon_ready", bus1.rt_xrf_ready, exp_rdy);
            chk("mon_count", bus1.fifo_count, model_cnt);
            chk("mon_idle", bus1.wb_idle, model_cnt == 0);
            pops = 0;
            if (!bus1.xrf_wr_stall && model_cnt > 0 && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                pops = 1;
                chk("mon_en", bus1.xrf_wr_en, e.a != 5'd0);
                if (e.a != 5'd0) begin
                    chk("mon_addr", bus1.xrf_wr_addr, e.a);
                    chk("mon_data", bus1.xrf_wr_data, e.d);
                end
            end else begin
                chk("mon_en_idle", bus1.xrf_wr_en, 1'b0);
            end
            pushes = 0;
            for (int i = 0; i < 4; i++) begin
                if (bus1.rt_xrf_valid[i] && exp_rdy[i]) begin
                    sb_q.push_back({bus1.rt_xrf_index[i*5 +: 5], bus1.rt_xrf_data[i*32 +: 32]});
                    pushes++;
                end
            end
            model_cnt = model_cnt + pushes - pops;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus1.rt_xrf_valid = '0; bus1.rt_xrf_index = '0; bus1.rt_xrf_data = '0; bus1.xrf_wr_stall = 1'b0;
        bus2.rt_xrf_valid = '0; bus2.rt_xrf_index = '0; bus2.rt_xrf_data = '0; bus2.xrf_wr_stall = 1'b0;

        // rst, stall, valid, idx {l3,l2,l1,l0}, data {l3,l2,l1,l0}, ready seen, count seen
        add(1'b0, 1'b0, 4'b0001, {15'd0, 5'd5}, {96'd0, 32'hDEADBEEF}, 4'b1111, 0);
        add(1'b0, 1'b0, 4'b0000, 20'd0, 128'd0, 4'b1111, 1);
        add(1'b0, 1'b0, 4'b0000, 20'd0, 128'd0, 4'b1111, 0);
        add(1'b0, 1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h44, 32'h33, 32'h22, 32'h11}, 4'b1111, 0);
        for (int c = 4; c >= 1; c--) add(1'b0, 1'b0, 4'b0000, 20'd0, 128'd0, 4'b1111, c);
        add(1'b0, 1'b1, 4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, {32'h1300, 32'h1200, 32'h1100, 32'h1000}, 4'b1111, 0);
        add(1'b0, 1'b1, 4'b1111, {5'd17, 5'd16, 5'd15, 5'd14}, {32'h1700, 32'h1600, 32'h1500, 32'h1400}, 4'b1111, 4);
        add(1'b0, 1'b1, 4'b0000, 20'd0, 128'd0, 4'b0000, 8);
        add(1'b0, 1'b0, 4'b0000, 20'd0, 128'd0, 4'b0000, 8);
        add(1'b0, 1'b0, 4'b0000, 20'd0, 128'd0, 4'b0001, 7);
        add(1'b0, 1'b0, 4'b0000, 20'd0, 128'd0, 4'b0011, 6);
        add(1'b0, 1'b0, 4'b0000, 20'd0, 128'd0, 4'b0111, 5);
        for (int c = 4; c >= 0; c--) add(1'b0, 1'b0, 4'b0000, 20'd0, 128'd0, 4'b1111, c);
        add(1'b0, 1'b0, 4'b0011, {15'd0, 5'd7, 5'd0}, {64'd0, 32'h2, 32'h1}, 4'b1111, 0);
        add(1'b0, 1'b0, 4'b0000, 20'd0, 128'd0, 4'b1111, 2);
        add(1'b0, 1'b0, 4'b0000, 20'd0, 128'd0, 4'b1111, 1);
        add(1'b0, 1'b0, 4'b0000, 20'd0, 128'd0, 4'b1111, 0);
        add(1'b0, 1'b1, 4'b1111, {5'd23, 5'd22, 5'd21, 5'd20}, {32'h23, 32'h22, 32'h21, 32'h20}, 4'b1111, 0);
        add(1'b0, 1'b1, 4'b0011, {10'd0, 5'd25, 5'd24}, {64'd0, 32'h25, 32'h24}, 4'b1111, 4);
        add(1'b1, 1'b1, 4'b0000, 20'd0, 128'd0, 4'b0011, 6);
        add(1'b0, 1'b0, 4'b0000, 20'd0, 128'd0, 4'b1111, 0);
        add(1'b0, 1'b0, 4'b0000, 20'd0, 128'd0, 4'b1111, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", bus1.fifo_count, 4'd0);
        chk("reset_idle", bus1.wb_idle, 1'b1);
        chk("reset_en", bus1.xrf_wr_en, 1'b0);
        chk("reset_ready", bus1.rt_xrf_ready, 4'b1111);

        foreach (vecs[r]) begin
            rst               = vecs[r].rst;
            bus1.xrf_wr_stall = vecs[r].stall;
            bus1.rt_xrf_valid = vecs[r].valid;
            bus1.rt_xrf_index = vecs[r].idx;
            bus1.rt_xrf_data  = vecs[r].data;
            @(negedge clk);
            chk($sformatf("row%0d_count", r), bus1.fifo_count, vecs[r].cnt);
            chk($sformatf("row%0d_ready", r), bus1.rt_xrf_ready, vecs[r].rdy);
            chk($sformatf("row%0d_idle", r), bus1.wb_idle, vecs[r].cnt == 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus1.rt_xrf_valid = '0; bus1.xrf_wr_stall = 1'b0;

        // Two-port instance: x9=0xA then x9=0xB queued under stall, then drained together.
        bus2.rt_xrf_valid = 4'b0011; bus2.rt_xrf_index = {10'd0, 5'd9, 5'd9};
        bus2.rt_xrf_data  = {64'd0, 32'hB, 32'hA}; bus2.xrf_wr_stall = 1'b1;
        @(negedge clk);
        chk("waw_pre_en", bus2.xrf_wr_en, 2'b00);
        @(posedge clk); #1;
        bus2.rt_xrf_valid = 4'b0000; bus2.xrf_wr_stall = 1'b0;
        @(negedge clk);
        chk("waw_stall_count", bus2.fifo_count, 4'd2);
        chk("waw_en", bus2.xrf_wr_en, 2'b10);
        chk("waw_addr1", bus2.xrf_wr_addr[9:5], 5'd9);
        chk("waw_data1", bus2.xrf_wr_data[63:32], 32'hB);
        @(posedge clk); #1;
        @(negedge clk);
        chk("waw_post_count", bus2.fifo_count, 4'd0);
        chk("waw_post_idle", bus2.wb_idle, 1'b1);

        // Two-port: distinct indices both write; then a collision group and an x0 group.
        bus2.rt_xrf_valid = 4'b0011; bus2.rt_xrf_index = {10'd0, 5'd4, 5'd3};
        bus2.rt_xrf_data  = {64'd0, 32'h2, 32'h1};
        @(posedge clk); #1;
        bus2.rt_xrf_valid = 4'b0000;
        @(negedge clk);
        chk("dual_en", bus2.xrf_wr_en, 2'b11);
        chk("dual_addr", bus2.xrf_wr_addr, {5'd4, 5'd3});
        chk("dual_data", bus2.xrf_wr_data, {32'h2, 32'h1});
        @(posedge clk); #1;
        bus2.rt_xrf_valid = 4'b1111; bus2.rt_xrf_index = {5'd0, 5'd5, 5'd6, 5'd6};
        bus2.rt_xrf_data  = {32'h4, 32'h3, 32'h2, 32'h1};
        @(posedge clk); #1;
        bus2.rt_xrf_valid = 4'b0000;
        @(negedge clk);
        chk("grp1_count", bus2.fifo_count, 4'd4);
        chk("grp1_en", bus2.xrf_wr_en, 2'b10);
        chk("grp1_data1", bus2.xrf_wr_data[63:32], 32'h2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("grp2_count", bus2.fifo_count, 4'd2);
        chk("grp2_en", bus2.xrf_wr_en, 2'b01);
        chk("grp2_addr0", bus2.xrf_wr_addr[4:0], 5'd5);
        chk("grp2_data0", bus2.xrf_wr_data[31:0], 32'h3);
        @(posedge clk); #1;
        @(negedge clk);
        chk("grp_end_count", bus2.fifo_count, 4'd0);
        chk("grp_end_en", bus2.xrf_wr_en, 2'b00);

        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
